// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared defaults, limits and types for the multi-port register file
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_RD         = 4;
  localparam int MAX_WR         = 3;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : per-register busy bits, issue acceptance, read-busy flags, pending count
// Revision       : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR-1:0]            we,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_wa,
  output logic                         iss_ok,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic [ADDR_WIDTH:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  wr_clr;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // One bit per register that is being written back this cycle
  always_comb begin
    wr_clr = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j] && (wa[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        wr_clr[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  assign iss_ok = iss_valid & ~rst &
                  ((iss_wa == '0) | ~busy[iss_wa] | wr_clr[iss_wa]);

  // Set is applied after clear so a same-cycle issue keeps the register busy
  always_comb begin
    busy_nxt = busy & ~wr_clr;
    if (iss_ok && (iss_wa != '0)) begin
      busy_nxt[iss_wa] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
      logic [ADDR_WIDTH-1:0] addr;
      assign addr       = ra[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_busy[i] = (addr != '0) & busy[addr] & ~wr_clr[addr];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/reg_files_mp.sv
// ============================================================================
// reg_files_mp : multi-port register file with write-first bypass and scoreboard
// Revision     : 1.0
// ============================================================================
`default_nettype none

module reg_files_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
  input  logic [NUM_WR-1:0]            we,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_wa,
  output logic                         iss_ok,
  output logic [ADDR_WIDTH:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];

  // Later ports are applied last, so the highest-index enabled port wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        rf[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (wa[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
          rf[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wd[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] rd_v;
      assign addr = ra[i*ADDR_WIDTH +: ADDR_WIDTH];
      always_comb begin
        rd_v = rf[addr];
        for (int j = 0; j < NUM_WR; j++) begin
          if (we[j] && (wa[j*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
            rd_v = wd[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (addr == '0) begin
          rd_v = '0;
        end
      end
      assign rd[i*DATA_WIDTH +: DATA_WIDTH] = rd_v;
    end
  endgenerate

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .ra        (ra),
    .wa        (wa),
    .we        (we),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .iss_ok    (iss_ok),
    .rd_busy   (rd_busy),
    .pend_cnt  (pend_cnt)
  );

endmodule

`default_nettype wire

// File: doc/reg_files_mp.md
# reg_files_mp

Parametrised multi-port register file with an integrated register scoreboard for the pipelined CPU. It offers NUM_RD asynchronous write-first read ports and NUM_WR synchronous write ports. Per-register busy bits track in-flight destinations, so decode can detect RAW and WAW hazards. It sits between decode (reads, issue) and writeback (writes), and replaces the single-write-port register file.

## Interface
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..3)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- ra  in  NUM_RD*ADDR_WIDTH  read addresses; port i = ra[i*ADDR_WIDTH +: ADDR_WIDTH]
- rd  out  NUM_RD*DATA_WIDTH  read data, combinational
- rd_busy  out  NUM_RD  read port i targets a pending register not written this cycle
- wa  in  NUM_WR*ADDR_WIDTH  write addresses
- wd  in  NUM_WR*DATA_WIDTH  write data
- we  in  NUM_WR  write enables
- iss_valid  in  1  decode requests to mark a destination busy
- iss_wa  in  ADDR_WIDTH  destination being issued
- iss_ok  out  1  issue accepted this cycle (combinational)
- pend_cnt  out  ADDR_WIDTH+1  registered count of busy registers

## Operation
- Register 0 reads as 0 at all times. Writes to it are dropped. It is never busy.
- Write-port priority: on an address collision, the highest-index write port with we=1 wins, both for storage and for bypass.
- **Read path.**
  - rd[i] equals the winning wd when any we[j]=1 with wa[j]==ra[i]!=0.
  - Otherwise rd[i] = rf[ra[i]].
- **Write path.** On posedge, if not rst, every enabled port with a nonzero address stores its data. Collisions are resolved by the priority rule above.
- **Scoreboard clear.** Every enabled write with a nonzero address clears busy[wa] at the posedge.
- **Scoreboard set.** iss_ok = iss_valid & !rst & (iss_wa==0 | !busy[iss_wa] | some we[j] with wa[j]==iss_wa).
  - If iss_ok and iss_wa!=0, busy[iss_wa] is set at the posedge.
  - Set beats a same-cycle clear: the new producer owns the register.
  - iss_wa==0 gives iss_ok=1 with no busy change.
- **Read busy flag.** rd_busy[i] = busy[ra[i]] & no enabled write to ra[i] this cycle. Forced to 0 for ra[i]==0.
- **Pending count.** pend_cnt is the population count of busy after the posedge update, held in a register. It ranges 0..2**ADDR_WIDTH-1.
- **Reset.** While rst=1 at a posedge:
  - all rf entries and all busy bits clear to 0, and pend_cnt clears to 0;
  - writes and issues in that cycle are discarded;
  - iss_ok is 0 while rst=1.
  - Combinational outputs during the rst=1 cycle follow current state.

## Timing
- Read latency is 0 cycles, with same-cycle bypass from all write ports.
- Write latency is 1 cycle: data is visible from storage the cycle after we.
- Busy set and clear take effect at the posedge. rd_busy and iss_ok reflect the new state in the next cycle.
- pend_cnt updates at the same posedge as busy.
- After reset deasserts, the first cycle reads all zeros, pend_cnt=0, and no register is busy.
- No multi-cycle handshake: iss_valid is a one-cycle pulse. If iss_ok=0, decode must stall and hold the request.

## Structure
- The package regfile_pkg holds:
  - default ADDR_WIDTH and DATA_WIDTH;
  - typedefs reg_addr_t and reg_data_t;
  - the MAX_RD=4 and MAX_WR=3 limits.
- One sub-module, reg_scoreboard, holds the busy vector, issue/clear arbitration, iss_ok, rd_busy and pend_cnt. The top level holds storage, write priority and bypass muxing.

## Test plan
- **Reset clear:** write x5=0xDEADBEEF, assert rst for 1 cycle -> rd of x5 = 0, pend_cnt=0, all rd_busy=0.
- **Write collision:** same cycle we[0] wa=7 wd=0x11 and we[1] wa=7 wd=0x22.
  - Same cycle: rd(x7) = 0x22 via bypass.
  - Next cycle: rd(x7) = 0x22 from storage.
- **x0 immunity:** we[1] wa=0 wd=0xFFFF_FFFF together with iss_valid iss_wa=0 -> rd(x0)=0, iss_ok=1, pend_cnt=0.
- **RAW/WAW:**
  - Issue x3 -> next cycle rd_busy=1 for ra=3, pend_cnt=1.
  - A second issue of x3 -> iss_ok=0.
  - Write x3=0x42 -> same cycle rd_busy=0 and rd=0x42; next cycle pend_cnt=0.
- **Set-beats-clear:** write x9 and issue x9 in the same cycle -> iss_ok=1; next cycle x9 holds the new data, busy[x9]=1, pend_cnt unchanged.
- **Reset mid-operation:** issue x4 and x6, then assert rst together with we wa=4 and iss_valid wa=8 -> next cycle rf[4]=0, no register busy, pend_cnt=0.
